// File: rtl/sr_latch_bist.sv
// sr_latch_bist
// Built-in self-test controller for a gated SR latch. It drives EN/S/R from
// a fixed vector ROM, waits a programmable settle time, samples Q/Qbar
// through synchronizers and compares them against golden values.
//
// Optional build macro: SR_BIST_INVALID_EN
//   Appends vector 8 (EN=S=R=1, expect Q=Qbar=0) and widens the index and
//   fail_idx to 4 bits.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             single-cycle run request (ignored while busy)
//   lat_en/s/r        registered latch drives
//   lat_q, lat_qbar   latch outputs, asynchronous to clk
//   busy              high in APPLY/SETTLE/CHECK
//   done, pass        run finished / finished with no mismatches
//   fail_idx          index of the first failing vector
//   err_count         mismatching vectors, saturates at 15
module sr_latch_bist #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
`ifdef SR_BIST_INVALID_EN
  localparam int IDX_W = 4
`else
  localparam int IDX_W = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             lat_en,
  output logic             lat_s,
  output logic             lat_r,
  input  logic             lat_q,
  input  logic             lat_qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_idx,
  output logic [3:0]       err_count
);

`ifdef SR_BIST_INVALID_EN
  localparam logic [IDX_W-1:0] LAST = IDX_W'(8);
`else
  localparam logic [IDX_W-1:0] LAST = IDX_W'(7);
`endif
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    cnt;

  // {en, s, r, exp_q, exp_qbar}
  function automatic logic [4:0] rom(input logic [IDX_W-1:0] i);
    case (i)
      IDX_W'(0): rom = 5'b101_01;
      IDX_W'(1): rom = 5'b100_01;
      IDX_W'(2): rom = 5'b110_10;
      IDX_W'(3): rom = 5'b100_10;
      IDX_W'(4): rom = 5'b001_10;
      IDX_W'(5): rom = 5'b101_01;
      IDX_W'(6): rom = 5'b010_01;
      IDX_W'(7): rom = 5'b110_10;
`ifdef SR_BIST_INVALID_EN
      // forbidden input of a NOR latch: both outputs low
      IDX_W'(8): rom = 5'b111_00;
`endif
      default:   rom = 5'b000_01;
    endcase
  endfunction

  logic [4:0] vec;
  assign vec = rom(idx);

  // Q/Qbar synchronizers
  logic [SYNC_STAGES-1:0] q_sync, qb_sync;
  logic sync_q, sync_qb, mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync  <= '0;
      qb_sync <= '0;
    end else begin
      q_sync  <= {q_sync[SYNC_STAGES-2:0], lat_q};
      qb_sync <= {qb_sync[SYNC_STAGES-2:0], lat_qbar};
    end
  end

  assign sync_q   = q_sync[SYNC_STAGES-1];
  assign sync_qb  = qb_sync[SYNC_STAGES-1];
  assign mismatch = (sync_q != vec[1]) || (sync_qb != vec[0]);
  assign busy     = (state == APPLY) || (state == SETTLE) || (state == CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = APPLY;
      APPLY:      state_next = SETTLE;
      SETTLE:     if (cnt == '0) state_next = CHECK;
      CHECK:      state_next = (idx == LAST) ? DONE : APPLY;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      lat_en    <= 1'b0;
      lat_s     <= 1'b0;
      lat_r     <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_idx  <= '0;
      err_count <= '0;
    end else begin
      // Status is registered off the settled DONE state, so it rises one
      // edge after the last CHECK and drops on the edge that leaves DONE.
      done <= (state == DONE) && (state_next == DONE);
      pass <= (state == DONE) && (state_next == DONE) && (err_count == 4'd0);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            fail_idx  <= '0;
          end
        end
        APPLY: begin
          {lat_en, lat_s, lat_r} <= vec[4:2];
          cnt <= CW'(SETTLE_CYCLES - 1);
        end
        SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        CHECK: begin
          if (mismatch) begin
            if (err_count != 4'd15) err_count <= err_count + 4'd1;
            // err_count never returns to zero within a run, so zero marks
            // the first mismatch
            if (err_count == 4'd0) fail_idx <= idx;
          end
          if (idx == LAST) {lat_en, lat_s, lat_r} <= 3'b000;
          else             idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
